// File: rtl/i2c_target.sv
// i2c_target: I2C target endpoint for 7-bit address frames. Received write bytes
// are packed MSB-first into a 32-bit word; read bytes come from a 32-bit word
// captured when the address is acknowledged.
//
// Ports:
//   clk_i     system clock (>= 8x SCL)
//   rst_i     asynchronous active-low reset
//   scl       bus clock input
//   sda       bus data, open-drain (driven 0 or released)
//   tx_data   read-return word, byte 0 = tx_data[31:24]
//   rx_data   last received write word, unreceived low lanes zero
//   rx_bytes  number of bytes held in rx_data (0..4)
//   rx_valid  1-cycle pulse when a matched write ends (STOP or repeated START)
//   rd_done   1-cycle pulse when a matched read ends (master NACK, STOP or Sr)
//   busy      high from address match until STOP, repeated START or mismatch
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl,
  inout  wire         sda,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic [2:0]  rx_bytes,
  output logic        rx_valid,
  output logic        rd_done,
  output logic        busy
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MAX_BYTES = 4;
  localparam int unsigned BCNT_W    = 4;
  localparam int unsigned RCNT_W    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_RX,
    S_ACK_R,
    S_NACK_R,
    S_TX,
    S_MACK
  } state_e;

  // Bus input synchronisers and one-cycle history for edge decoding
  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_hist_q;
  logic       sda_hist_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  logic scl_s_c, sda_s_c;
  logic scl_rise_c, scl_fall_c, start_c, stop_c;

  assign scl_s_c    = scl_sync_q[1];
  assign sda_s_c    = sda_sync_q[1];
  assign scl_rise_c = scl_s_c & ~scl_hist_q;
  assign scl_fall_c = ~scl_s_c & scl_hist_q;
  assign start_c    = scl_s_c & scl_hist_q & sda_hist_q & ~sda_s_c;
  assign stop_c     = scl_s_c & scl_hist_q & ~sda_hist_q & sda_s_c;

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-2:0]   sh_q, sh_d;       // previous 7 bits; 8th bit joins from sda
  logic                rw_q, rw_d;
  logic                ack_ph_q, ack_ph_d; // 0: before ninth-bit drive, 1: driving
  logic [WORD_W-1:0]   tx_sh_q, tx_sh_d;
  logic [WORD_W-1:0]   rx_buf_q, rx_buf_d;
  logic [RCNT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic                wr_act_q, wr_act_d;
  logic                rd_act_q, rd_act_d;
  logic                sda_oe_q, sda_oe_d;
  logic [WORD_W-1:0]   rx_data_q, rx_data_d;
  logic [RCNT_W-1:0]   rx_bytes_q, rx_bytes_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rd_done_q, rd_done_d;
  logic                busy_q, busy_d;
  logic [BYTE_W-1:0]   byte_c;

  assign byte_c = {sh_q, sda_s_c};

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      rw_q       <= 1'b0;
      ack_ph_q   <= 1'b0;
      tx_sh_q    <= '0;
      rx_buf_q   <= '0;
      rx_cnt_q   <= '0;
      wr_act_q   <= 1'b0;
      rd_act_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_bytes_q <= '0;
      rx_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      ack_ph_q   <= ack_ph_d;
      tx_sh_q    <= tx_sh_d;
      rx_buf_q   <= rx_buf_d;
      rx_cnt_q   <= rx_cnt_d;
      wr_act_q   <= wr_act_d;
      rd_act_q   <= rd_act_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_bytes_q <= rx_bytes_d;
      rx_valid_q <= rx_valid_d;
      rd_done_q  <= rd_done_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    rw_d       = rw_q;
    ack_ph_d   = ack_ph_q;
    tx_sh_d    = tx_sh_q;
    rx_buf_d   = rx_buf_q;
    rx_cnt_d   = rx_cnt_q;
    wr_act_d   = wr_act_q;
    rd_act_d   = rd_act_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_bytes_d = rx_bytes_q;
    rx_valid_d = 1'b0;
    rd_done_d  = 1'b0;

    if (start_c || stop_c) begin
      // Bus conditions override any bit-level activity
      sda_oe_d  = 1'b0;
      ack_ph_d  = 1'b0;
      bit_cnt_d = '0;
      if (wr_act_q) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_buf_q;
        rx_bytes_d = rx_cnt_q;
      end
      if (rd_act_q) begin
        rd_done_d = 1'b1;
      end
      wr_act_d = 1'b0;
      rd_act_d = 1'b0;
      state_d  = start_c ? S_ADDR : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          sda_oe_d = 1'b0;
        end

        S_ADDR: begin
          if (scl_rise_c) begin
            sh_d      = {sh_q[BYTE_W-3:0], sda_s_c};
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            if (bit_cnt_q == BCNT_W'(BYTE_W - 1)) begin
              bit_cnt_d = '0;
              if (sh_q == TARGET_ADDR) begin
                state_d  = S_ACK_A;
                rw_d     = sda_s_c;
                ack_ph_d = 1'b0;
                if (sda_s_c) begin
                  tx_sh_d  = tx_data;
                  rd_act_d = 1'b1;
                end else begin
                  rx_buf_d = '0;
                  rx_cnt_d = '0;
                  wr_act_d = 1'b1;
                end
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        end

        S_ACK_A, S_ACK_R, S_NACK_R: begin
          if (scl_fall_c) begin
            if (!ack_ph_q) begin
              ack_ph_d = 1'b1;
              sda_oe_d = (state_q != S_NACK_R);
            end else begin
              ack_ph_d  = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == S_ACK_A && rw_q) begin
                // This fall both ends the ACK and launches the first read bit
                state_d   = S_TX;
                sda_oe_d  = ~tx_sh_q[WORD_W-1];
                tx_sh_d   = {tx_sh_q[WORD_W-2:0], 1'b1};
                bit_cnt_d = BCNT_W'(1);
              end else begin
                state_d = S_RX;
              end
            end
          end
        end

        S_RX: begin
          if (scl_rise_c) begin
            sh_d      = {sh_q[BYTE_W-3:0], sda_s_c};
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            if (bit_cnt_q == BCNT_W'(BYTE_W - 1)) begin
              bit_cnt_d = '0;
              ack_ph_d  = 1'b0;
              if (rx_cnt_q < RCNT_W'(MAX_BYTES)) begin
                unique case (rx_cnt_q[1:0])
                  2'd0: rx_buf_d[31:24] = byte_c;
                  2'd1: rx_buf_d[23:16] = byte_c;
                  2'd2: rx_buf_d[15:8]  = byte_c;
                  2'd3: rx_buf_d[7:0]   = byte_c;
                  default: rx_buf_d = rx_buf_q;
                endcase
                rx_cnt_d = rx_cnt_q + RCNT_W'(1);
                state_d  = S_ACK_R;
              end else begin
                state_d = S_NACK_R;
              end
            end
          end
        end

        S_TX: begin
          if (scl_fall_c) begin
            if (bit_cnt_q == BCNT_W'(BYTE_W)) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_MACK;
            end else begin
              // Ones shift in behind the word, so bytes past the fourth read 8'hFF
              sda_oe_d  = ~tx_sh_q[WORD_W-1];
              tx_sh_d   = {tx_sh_q[WORD_W-2:0], 1'b1};
              bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            end
          end
        end

        S_MACK: begin
          if (scl_rise_c) begin
            if (sda_s_c) begin
              state_d   = S_IDLE;
              rd_done_d = 1'b1;
              rd_act_d  = 1'b0;
            end else begin
              state_d = S_TX;
            end
          end
        end

        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_ADDR);
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_bytes = rx_bytes_q;
  assign rx_valid = rx_valid_q;
  assign rd_done  = rd_done_q;
  assign busy     = busy_q;

endmodule
